// File: rtl/hwa_frame_sched_if.sv
// Handshake and front-end bus between the frame sequencer and its neighbours:
// upstream sample source, HWA lane array and downstream result consumer.
interface hwa_frame_sched_if #(
  parameter int N     = 12,
  parameter int LANES = 4
);
  localparam int W = N + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         in_data;
  logic                 flush;
  logic [W-1:0]         hwa_in;
  logic                 hwa_shift;
  logic                 hwa_start;
  logic [LANES*W-1:0]   hwa_out;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*W-1:0]   out_data;
  logic [LANES-1:0]     out_lane_valid;
  logic                 busy;

  modport slave (
    input  in_valid, in_data, flush, hwa_out, out_ready,
    output in_ready, hwa_in, hwa_shift, hwa_start,
           out_valid, out_data, out_lane_valid, busy
  );

  modport master (
    output in_valid, in_data, flush, hwa_out, out_ready,
    input  in_ready, hwa_in, hwa_shift, hwa_start,
           out_valid, out_data, out_lane_valid, busy
  );
endinterface

// File: rtl/hwa_frame_sched.sv
// Frame sequencer for the 4-lane stochastic FIR/decimator array: loads one sample,
// starts the RNG/HWA window, times it, and captures lane results with per-lane validity.
module hwa_frame_sched #(
  parameter int N     = 12,
  parameter int WIN   = 4096,
  parameter int LEN   = 19,
  parameter int LANES = 4
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  hwa_frame_sched_if.slave io_bus
);
  localparam int W  = N + 1;
  localparam int FW = $clog2(LEN * 8 + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(LEN * 8);
  localparam logic [N-1:0]  CNT_LAST = N'(WIN - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_START   = 3'd2,
    S_RUN     = 3'd3,
    S_CAPTURE = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [N-1:0]       r_win_cnt;
  logic [2:0]         r_phase;
  logic [FW-1:0]      r_fill;
  logic               r_flush_pend;
  logic               r_in_ready;
  logic               r_hwa_shift;
  logic               r_hwa_start;
  logic               r_out_valid;
  logic               r_busy;
  logic [W-1:0]       r_hwa_in;
  logic [LANES*W-1:0] r_out_data;
  logic [LANES-1:0]   r_out_lane_valid;

  logic               w_accept;
  logic               w_cnt_last;
  logic               w_flush_any;
  logic [FW-1:0]      w_fill_next;
  logic [LANES-1:0]   w_lane_valid;

  assign w_accept    = (r_state == S_IDLE) && r_in_ready && io_bus.in_valid;
  assign w_cnt_last  = (r_win_cnt == CNT_LAST);
  assign w_flush_any = io_bus.flush | r_flush_pend;
  assign w_fill_next = (r_fill >= FILL_MAX) ? FILL_MAX : (r_fill + FW'(1));

  assign io_bus.in_ready       = r_in_ready;
  assign io_bus.hwa_in         = r_hwa_in;
  assign io_bus.hwa_shift      = r_hwa_shift;
  assign io_bus.hwa_start      = r_hwa_start;
  assign io_bus.out_valid      = r_out_valid;
  assign io_bus.out_data       = r_out_data;
  assign io_bus.out_lane_valid = r_out_lane_valid;
  assign io_bus.busy           = r_busy;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = S_LOAD;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_LOAD:    w_next = S_START;
      S_START:   w_next = S_RUN;
      S_RUN: begin
        if (w_cnt_last) begin
          w_next = S_CAPTURE;
        end else begin
          w_next = S_RUN;
        end
      end
      S_CAPTURE: w_next = S_HOLD;
      S_HOLD: begin
        if (io_bus.out_ready) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_HOLD;
        end
      end
      default:   w_next = S_IDLE;
    endcase
  end

  // Lane k (decimation 2^k) is valid on the last phase of its decimation group once its cascade has filled.
  always_comb begin
    w_lane_valid    = '0;
    w_lane_valid[0] = (w_fill_next >= FW'(LEN));
    for (int k = 1; k < LANES; k++) begin
      w_lane_valid[k] = ((r_phase & 3'((1 << k) - 1)) == 3'((1 << k) - 1)) &&
                        (w_fill_next >= FW'(LEN << k));
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state          <= S_IDLE;
      r_in_ready       <= 1'b0;
      r_hwa_shift      <= 1'b0;
      r_hwa_start      <= 1'b0;
      r_out_valid      <= 1'b0;
      r_busy           <= 1'b0;
      r_hwa_in         <= '0;
      r_win_cnt        <= '0;
      r_phase          <= 3'd0;
      r_fill           <= '0;
      r_flush_pend     <= 1'b0;
      r_out_data       <= '0;
      r_out_lane_valid <= '0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next == S_IDLE);
      r_hwa_shift <= (w_next == S_LOAD);
      r_hwa_start <= (w_next == S_START);
      r_out_valid <= (w_next == S_HOLD);
      r_busy      <= (w_next != S_IDLE);

      if (w_accept) begin
        r_hwa_in <= io_bus.in_data;
      end

      if (r_state == S_START) begin
        r_win_cnt <= '0;
      end else if ((r_state == S_RUN) && !w_cnt_last) begin
        r_win_cnt <= r_win_cnt + N'(1);
      end

      // A flush seen mid-frame is held until capture so the in-flight frame reports no valid lanes.
      case (r_state)
        S_IDLE, S_HOLD: begin
          r_flush_pend <= 1'b0;
          if (io_bus.flush) begin
            r_phase <= 3'd0;
            r_fill  <= '0;
          end
        end
        S_LOAD, S_START, S_RUN: begin
          r_flush_pend <= r_flush_pend | io_bus.flush;
        end
        S_CAPTURE: begin
          r_out_data   <= io_bus.hwa_out;
          r_flush_pend <= 1'b0;
          if (w_flush_any) begin
            r_out_lane_valid <= '0;
            r_phase          <= 3'd0;
            r_fill           <= '0;
          end else begin
            r_out_lane_valid <= w_lane_valid;
            r_phase          <= r_phase + 3'd1;
            r_fill           <= w_fill_next;
          end
        end
        default: begin
          r_flush_pend <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hwa_frame_sched.sv
// Directed bench for hwa_frame_sched with a shortened window (N=6, WIN=64) so that
// long fill/phase sequences fit in a short run.
module tb_hwa_frame_sched;
  localparam int N     = 6;
  localparam int WIN   = 64;
  localparam int LEN   = 19;
  localparam int LANES = 4;
  localparam int W     = N + 1;
  localparam int DW    = LANES * W;

  logic clk = 1'b0;
  logic rst_n;

  hwa_frame_sched_if #(.N(N), .LANES(LANES)) bus ();

  hwa_frame_sched #(.N(N), .WIN(WIN), .LEN(LEN), .LANES(LANES)) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .io_bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_errors  = 0;
  int n_shift   = 0;
  int n_start   = 0;
  int n_overlap = 0;
  int m_fill    = 0;
  int m_phase   = 0;

  always @(negedge clk) begin
    if (bus.hwa_shift) n_shift++;
    if (bus.hwa_start) n_start++;
    if (bus.hwa_shift && bus.hwa_start) n_overlap++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_lv(input int fill, input int phase);
    logic [3:0] lv;
    int fn;
    fn    = (fill + 1 > LEN * 8) ? LEN * 8 : fill + 1;
    lv[0] = (fn >= LEN);
    for (int k = 1; k < 4; k++) begin
      lv[k] = ((phase % (1 << k)) == ((1 << k) - 1)) && (fn >= (LEN << k));
    end
    return lv;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1'b0);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_shift"}, bus.hwa_shift, 1'b0);
    check({tag, "_start"}, bus.hwa_start, 1'b0);
    check({tag, "_hwa_in"}, bus.hwa_in, '0);
    check({tag, "_out_data"}, bus.out_data, '0);
    check({tag, "_lane_valid"}, bus.out_lane_valid, 4'b0000);
  endtask

  // One frame: offer d, optionally pulse flush at cycle k (k=0 is the shift cycle), wait for out_valid.
  task automatic do_frame(input logic [W-1:0] d, input logic [DW-1:0] hout, input int flush_at,
                          input bit keep_valid, output logic [3:0] lv_got);
    int k;
    int base_shift;
    logic [3:0] exp_lv;
    bus.hwa_out = hout;
    base_shift  = n_shift;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    k = 0;
    while (!bus.in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("accept_wait", (k < 20), 1'b1);
    @(posedge clk);
    if (!keep_valid) begin
      #1;
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    check("shift", bus.hwa_shift, 1'b1);
    check("hwa_in", bus.hwa_in, d);
    check("start_early", bus.hwa_start, 1'b0);
    @(negedge clk);
    check("start", bus.hwa_start, 1'b1);
    check("shift_once", bus.hwa_shift, 1'b0);
    k = 1;
    while (!bus.out_valid && k < WIN + 20) begin
      bus.flush = (k == flush_at);
      @(negedge clk);
      k++;
    end
    bus.flush = 1'b0;
    check("latency", k, WIN + 3);
    if (flush_at >= 0) begin
      exp_lv  = 4'b0000;
      m_fill  = 0;
      m_phase = 0;
    end else begin
      exp_lv  = model_lv(m_fill, m_phase);
      m_fill  = (m_fill + 1 > LEN * 8) ? LEN * 8 : m_fill + 1;
      m_phase = (m_phase + 1) % 8;
    end
    check("lane_valid", bus.out_lane_valid, exp_lv);
    check("out_data", bus.out_data, hout);
    check("busy_hold", bus.busy, 1'b1);
    check("in_ready_hold", bus.in_ready, 1'b0);
    check("shifts_per_frame", n_shift - base_shift, 1);
    lv_got = bus.out_lane_valid;
  endtask

  initial begin
    logic [3:0]    lv;
    logic [DW-1:0] held;
    int            base_shift;
    int            seen;

    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.flush      = 1'b0;
    bus.hwa_out    = '0;
    bus.out_ready  = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1'b1);
    check("reset_busy_idle", bus.busy, 1'b0);

    // Test 1: single sample, frame 1 has no valid lane
    do_frame(7'h25, 28'h0A5_1234, -1, 1'b0, lv);
    check("t1_lv", lv, 4'b0000);

    // Test 2: frames 2..160
    for (int f = 2; f <= 160; f++) begin
      do_frame(W'(f), DW'(f * 32'h0123457 + 5), -1, 1'b0, lv);
      case (f)
        18:      check("t2_f18", lv, 4'b0000);
        19:      check("t2_f19", lv, 4'b0001);
        38:      check("t2_f38", lv, 4'b0011);
        76:      check("t2_f76", lv, 4'b0111);
        151:     check("t2_f151", lv, 4'b0001);
        152:     check("t2_f152", lv, 4'b1111);
        160:     check("t2_f160", lv, 4'b1111);
        default: ;
      endcase
    end

    // Test 3: out_ready low for 50 cycles in HOLD, in_valid offered meanwhile
    @(negedge clk);
    bus.out_ready = 1'b0;
    do_frame(7'h5A, 28'hBEEF123, -1, 1'b0, lv);
    held       = bus.out_data;
    base_shift = n_shift;
    bus.in_valid = 1'b1;
    bus.in_data  = 7'h11;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("t3_out_valid", bus.out_valid, 1'b1);
      check("t3_out_data", bus.out_data, held);
      check("t3_in_ready", bus.in_ready, 1'b0);
      check("t3_no_shift", n_shift - base_shift, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t3_release_valid", bus.out_valid, 1'b0);
    check("t3_release_ready", bus.in_ready, 1'b1);

    // Test 5: reset mid-window
    bus.in_valid = 1'b1;
    bus.in_data  = 7'h33;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (42) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_async");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_in_ready", bus.in_ready, 1'b1);
    m_fill  = 0;
    m_phase = 0;
    seen = 0;
    for (int i = 0; i < WIN + 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("t5_no_out_valid", seen, 0);

    // Test 4: 29 frames, flush in RUN of frame 30, then refill
    for (int f = 1; f <= 29; f++) begin
      do_frame(W'(f + 3), DW'(f * 32'h00F00D1), -1, 1'b0, lv);
    end
    check("t4_f29", lv, 4'b0001);
    do_frame(7'h30, 28'h3030303, 10, 1'b0, lv);
    check("t4_flush_frame", lv, 4'b0000);
    for (int j = 1; j <= 19; j++) begin
      do_frame(W'(j), DW'(j * 32'h0ABCDE1), -1, 1'b0, lv);
      check("t4_refill_lane0", lv[0], (j == 19));
    end

    // Test 6: flush coincident with CAPTURE, in_valid held high
    for (int j = 0; j < 3; j++) begin
      do_frame(W'(j + 40), DW'(j * 32'h1111111 + 7), WIN + 2, 1'b1, lv);
      check("t6_lv", lv, 4'b0000);
    end
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_idle", bus.busy, 1'b0);
    check("no_shift_start_overlap", n_overlap, 0);
    check("shift_start_pairs", n_start, n_shift);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
